// File: rtl/simpbus_responder.sv
// simpbus_responder: CPU bus responder with RAM, TX FIFO and status/count registers.
// Wait-state FSM (hold/STALL) is built only when SIMPBUS_WAIT_EN is defined.
module simpbus_responder #(
    parameter int RAM_AW = 10,
    parameter int WAIT = 1,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addrin,
    input  logic [15:0] datain,
    input  logic        cs,
    input  logic        write,
    output logic [15:0] dataout,
    output logic        hold,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam logic [15:0] TXDATA_A = 16'hFF00;
    localparam logic [15:0] TXCOUNT_A = 16'hFF01;

    if (WAIT < 0 || WAIT > 15) begin : g_wait_range
        $error("WAIT must be in 0..15");
    end

    logic [15:0] ram [2**RAM_AW];
    logic [15:0] fifo [1<<FIFO_AW];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0] count;
    logic ovf, empty, full, accept, is_ram, push_req, push, pop;
    logic [15:0] status, rd_data;

`ifdef SIMPBUS_WAIT_EN
    localparam logic [0:0] ACCEPT = 1'b0;
    localparam logic [0:0] STALL = 1'b1;
    logic [0:0] state;
    logic [3:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ACCEPT;
            cnt <= 4'd0;
            hold <= 1'b0;
        end else if (state == ACCEPT) begin
            if (cs && WAIT > 0) begin
                state <= STALL;
                cnt <= 4'(WAIT);
                hold <= 1'b1;
            end
        end else if (cnt == 4'd1) begin
            state <= ACCEPT;
            cnt <= 4'd0;
            hold <= 1'b0;
        end else
            cnt <= cnt - 1'b1;
    assign accept = cs && state == ACCEPT;
`else
    assign hold = 1'b0;
    assign accept = cs;
`endif

    assign empty = count == '0;
    assign full = count[FIFO_AW];
    assign status = {13'b0, ovf, full, empty};
    assign is_ram = (addrin >> RAM_AW) == 16'd0;
    assign rd_data = is_ram ? ram[addrin[RAM_AW-1:0]] :
                     addrin == TXDATA_A ? status :
                     addrin == TXCOUNT_A ? {{(15-FIFO_AW){1'b0}}, count} : 16'h0000;
    assign push_req = accept && write && addrin == TXDATA_A;
    assign pop = !empty && tx_ready;
    // a full FIFO still takes a push when the head leaves on the same edge
    assign push = push_req && (!full || pop);
    assign tx_valid = !empty;
    assign tx_data = empty ? 16'h0000 : fifo[rptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dataout <= 16'h0000;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            ovf <= 1'b0;
        end else begin
            if (accept && !write)
                dataout <= rd_data;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            if (push_req && !push)
                ovf <= 1'b1;
            else if (accept && !write && addrin == TXDATA_A)
                ovf <= 1'b0;
        end

    always_ff @(posedge clk) begin
        if (accept && write && is_ram)
            ram[addrin[RAM_AW-1:0]] <= datain;
        if (push)
            fifo[wptr] <= datain;
    end
endmodule

// File: doc/simpbus_responder.md
SIMPBUS_RESPONDER -- requirements
Module: simpbus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM address width (2^RAM_AW 16-bit words at 0x0000 upward).
REQ-002 SHALL have parameter WAIT, default 1, meaning wait cycles inserted per accepted access (range 0-15).
REQ-003 SHALL have parameter FIFO_AW, default 2, meaning TX FIFO depth of 2^FIFO_AW words.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port addrin  input  16  bus address from the CPU.
REQ-007 SHALL have port datain  input  16  write data from the CPU.
REQ-008 SHALL have port cs  input  1  bus select; access requested when high.
REQ-009 SHALL have port write  input  1  high = write access, low = read access.
REQ-010 SHALL have port dataout  output  16  registered read data to the CPU.
REQ-011 SHALL have port hold  output  1  registered stall to the CPU.
REQ-012 SHALL have ports tx_data  output  16, tx_valid  output  1, tx_ready  input  1: FIFO drain stream.

Function
REQ-013 SHALL decode: addrin < 2^RAM_AW -> RAM; 0xFF00 -> TXDATA (write pushes FIFO; read returns status); 0xFF01 -> TXCOUNT (read-only occupancy); all other addresses read 0x0000 and ignore writes.
REQ-014 SHALL define status = {13'b0, ovf, full, empty}.
REQ-015 SHALL use a two-state FSM, ACCEPT and STALL; reset enters ACCEPT.
REQ-016 SHALL accept an access in ACCEPT when cs=1: latch address and write flag, perform any write at that edge, and load dataout with read data (unchanged on writes) at that same edge (1-cycle read latency).
REQ-017 SHALL, on acceptance with WAIT>0, go to STALL with hold=1 and a down-counter loaded with WAIT; leave STALL when counter reaches 1, dropping hold on that edge; total hold high = WAIT cycles.
REQ-018 SHALL ignore cs, addrin, write and datain while in STALL; dataout stays stable.
REQ-019 SHALL, with WAIT=0, remain in ACCEPT with hold=0 and accept one access every cycle.
REQ-020 SHALL write RAM word addrin[RAM_AW-1:0] with datain on an accepted RAM write.
REQ-021 SHALL push datain on an accepted TXDATA write when not full; when full, drop the write and set ovf (sticky).
REQ-022 SHALL clear ovf on an accepted TXDATA read; the returned status shows ovf=1 that once.
REQ-023 SHALL present FIFO head on tx_data with tx_valid=1 whenever non-empty; pop when tx_valid and tx_ready.
REQ-024 SHALL, on simultaneous push and pop, accept both even when full (occupancy unchanged) and when empty treat it as push only (pop requires tx_valid).
REQ-025 SHALL wrap FIFO pointers modulo 2^FIFO_AW; TXCOUNT reports 0..2^FIFO_AW zero-extended to 16 bits.
REQ-026 SHALL return status/count values sampled before same-edge push/pop effects.

Reset
REQ-027 SHALL, while rst=1, force: FSM=ACCEPT, hold=0, dataout=0x0000, wait counter=0, FIFO empty (tx_valid=0, tx_data=0x0000), ovf=0.
REQ-028 SHALL abort any in-progress stall on reset without completing it; RAM contents are not reset.

Configuration
REQ-029 SHALL compile wait-state logic only when SIMPBUS_WAIT_EN is defined.
REQ-030 SHALL, with SIMPBUS_WAIT_EN defined, behave per REQ-017/018 using WAIT.
REQ-031 SHALL, without SIMPBUS_WAIT_EN, tie hold to 0, omit STALL and the counter, and ignore WAIT (zero-wait behaviour of REQ-019).

Verification
REQ-032 SHALL cover: RAM write 0x1234 to 0x0005, then read 0x0005 -> dataout=0x1234 one edge after read acceptance; with WAIT=2 hold high exactly 2 cycles per access.
REQ-033 SHALL cover: 5 writes 0x0A..0x0E to 0xFF00, tx_ready=0, FIFO_AW=2 -> TXCOUNT=4, status=0x0006, then status read clears ovf -> next status=0x0002.
REQ-034 SHALL cover: tx_ready=1 with 4 queued -> tx_data 0x0A,0x0B,0x0C,0x0D on successive cycles, then tx_valid=0, status=0x0001.
REQ-035 SHALL cover: full FIFO, push 0x55 with tx_ready=1 same cycle -> count stays 4, ovf=0, 0x55 emerges last.
REQ-036 SHALL cover: rst asserted mid-STALL -> hold=0, dataout=0x0000, tx_valid=0 immediately (asynchronous); read of 0x1234 (unmapped) -> 0x0000.
REQ-037 SHALL cover: build without SIMPBUS_WAIT_EN -> hold never rises, back-to-back reads of 0x0005 and 0xFF01 return data on consecutive cycles.
